// File: rtl/serial_device_pkg.sv
// Shared definitions for the serial transmit device: TX FSM encoding and
// status-register bit positions.
package serial_device_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int STAT_READY = 0;
  localparam int STAT_IDLE  = 1;
  localparam int STAT_OVF   = 2;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide TX FIFO. Pointers wrap naturally (power-of-two depth); count
// is one bit wider so full and empty are distinguishable.
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_bar,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_device.sv
// Memory-mapped 8N1 UART transmitter: data port pushes bytes into a FIFO,
// status port reports ready/idle/overflow, FSM serialises LSB first.
module serial_device
  import serial_device_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_bar,
  input  logic [15:0] bus_in,
  input  logic [15:0] addr,
  input  logic        DI,
  input  logic        DO,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  output logic        tx
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] STAT_ADDR = BASE_ADDR + 16'd1;
  localparam logic [15:0] BIT_END   = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q, ovf_q, ovf_d;

  logic        full, empty, pop, wr_data, rd_stat, drop, bit_end;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_cnt;
  logic [4:0]  cnt5;
  logic [15:0] status_w;
  logic        unused_bits;

  assign wr_data = DI && (addr == BASE_ADDR);
  assign rd_stat = DO && (addr == STAT_ADDR);
  assign bit_end = (baud_q == BIT_END);
  // Pop when leaving IDLE or at the last STOP cycle to chain frames back-to-back.
  assign pop     = !empty && ((state_q == ST_IDLE) || (state_q == ST_STOP && bit_end));
  assign drop    = wr_data && full && !pop;
  assign ovf_d   = drop ? 1'b1 : (rd_stat ? 1'b0 : ovf_q);

  assign cnt5        = 5'(fifo_cnt);
  assign unused_bits = ^{bus_in[15:8], cnt5[4]};

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_bar (reset_bar),
    .push      (wr_data),
    .pop       (pop),
    .din       (bus_in[7:0]),
    .dout      (fifo_dout),
    .full      (full),
    .empty     (empty),
    .count     (fifo_cnt)
  );

  always_comb begin
    status_w             = '0;
    status_w[STAT_READY] = !full;
    status_w[STAT_IDLE]  = empty && (state_q == ST_IDLE);
    status_w[STAT_OVF]   = ovf_q;
  end

  always_comb begin
    bus_oe  = DO && ((addr == BASE_ADDR) || (addr == STAT_ADDR));
    bus_out = '0;
    if (bus_oe) bus_out = (addr == STAT_ADDR) ? status_w : {12'b0, cnt5[3:0]};
  end

  assign tx = tx_q;

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            state_q <= ST_START;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= ST_DATA;
            tx_q    <= shift_q[0];
          end else baud_q <= baud_q + 16'd1;
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else baud_q <= baud_q + 16'd1;
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_dout;
              state_q <= ST_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              tx_q    <= 1'b1;
            end
          end else baud_q <= baud_q + 16'd1;
        end
        default: begin
          state_q <= ST_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_device.sv
// Self-checking bench: frame-level model (byte queue + time within frame)
// predicts bus reads and the tx waveform every cycle.
module tb_serial_device;

  localparam logic [15:0] BASE  = 16'h0020;
  localparam logic [15:0] STAT  = 16'h0021;
  localparam logic [15:0] UNMAP = 16'h0010;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset_bar;
  logic [15:0] bus_in, addr, bus_out;
  logic        DI, DO, bus_oe, tx;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mq[$];
  bit         m_busy, m_ovf;
  int         m_t;
  logic [7:0] m_cur;

  serial_device #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .bus_in    (bus_in),
    .addr      (addr),
    .DI        (DI),
    .DO        (DO),
    .bus_out   (bus_out),
    .bus_oe    (bus_oe),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_tx();
    if (!m_busy)             return 1'b1;
    if (m_t < CPB)           return 1'b0;
    if (m_t < 9 * CPB)       return m_cur[(m_t - CPB) / CPB];
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_bus(input logic dor, input logic [15:0] a);
    if (!dor) return 16'h0;
    if (a == STAT) return {13'b0, m_ovf, (mq.size() == 0 && !m_busy), (mq.size() < DEPTH)};
    if (a == BASE) return {12'b0, 4'(mq.size())};
    return 16'h0;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_busy = 0;
    m_ovf  = 0;
    m_t    = 0;
  endtask

  task automatic m_step(input logic di, input logic dor, input logic [15:0] a, input logic [15:0] d);
    bit pop, full, drop;
    logic [7:0] nb;
    nb   = 8'h00;
    full = (mq.size() == DEPTH);
    pop  = (mq.size() > 0) && (!m_busy || m_t == FRAME - 1);
    drop = di && (a == BASE) && full && !pop;
    if (pop) nb = mq.pop_front();
    if (di && a == BASE && !drop) mq.push_back(d[7:0]);
    if (drop) m_ovf = 1;
    else if (dor && a == STAT) m_ovf = 0;
    if (m_busy) begin
      m_t++;
      if (m_t == FRAME) begin
        if (pop) begin m_t = 0; m_cur = nb; end
        else m_busy = 0;
      end
    end else if (pop) begin
      m_busy = 1; m_t = 0; m_cur = nb;
    end
  endtask

  task automatic cyc(input logic di, input logic dor, input logic [15:0] a, input logic [15:0] d);
    DI = di; DO = dor; addr = a; bus_in = d;
    @(negedge clk);
    chk("bus_oe", {15'b0, bus_oe}, {15'b0, dor && (a == BASE || a == STAT)});
    chk("bus_out", bus_out, m_bus(dor, a));
    chk("tx", {15'b0, tx}, {15'b0, m_tx()});
    @(posedge clk);
    m_step(di, dor, a, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 16'h0);
  endtask

  initial begin
    reset_bar = 1'b0; DI = 0; DO = 0; addr = 0; bus_in = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 chk("rst_tx", {15'b0, tx}, 16'h0001);
    @(negedge clk) reset_bar = 1'b1;
    @(posedge clk); #1;

    // Reset status and tx.
    DO = 1; addr = STAT; #1;
    chk("rst_stat", bus_out, 16'h0003);
    chk("rst_oe", {15'b0, bus_oe}, 16'h0001);
    cyc(1'b0, 1'b1, STAT, 16'h0);

    // Single A5 frame, bus_in[15:8] ignored.
    cyc(1'b1, 1'b0, BASE, 16'hFFA5);
    cyc(1'b0, 1'b1, BASE, 16'h0);
    idle(FRAME + 4);
    cyc(1'b0, 1'b1, STAT, 16'h0);

    // Five back-to-back writes, no overflow, frames chained.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, BASE, 16'(i));
    cyc(1'b0, 1'b1, STAT, 16'h0);
    idle(5 * FRAME + 4);

    // Six writes back-to-back: one dropped, overflow read then cleared.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, BASE, 16'h30 + 16'(i));
    cyc(1'b0, 1'b1, STAT, 16'h0);
    chk("ovf_set", {15'b0, m_ovf}, 16'h0000);
    cyc(1'b0, 1'b1, STAT, 16'h0);
    idle(5 * FRAME);

    // Writes to status port and unmapped address do nothing.
    cyc(1'b1, 1'b0, STAT, 16'h0055);
    cyc(1'b1, 1'b1, UNMAP, 16'h0066);
    cyc(1'b0, 1'b1, BASE, 16'h0);
    idle(3);

    // Reset in the middle of a DATA bit.
    cyc(1'b1, 1'b0, BASE, 16'h00C3);
    cyc(1'b1, 1'b0, BASE, 16'h0011);
    idle(CPB + 6);
    #2 reset_bar = 1'b0;
    #1 chk("mid_rst_tx", {15'b0, tx}, 16'h0001);
    DO = 1; addr = BASE; DI = 0; #1;
    chk("mid_rst_cnt", bus_out, 16'h0000);
    addr = STAT; #1;
    chk("mid_rst_stat", bus_out, 16'h0003);
    m_reset();
    @(negedge clk) reset_bar = 1'b1; DO = 0;
    @(posedge clk); m_step(1'b0, 1'b0, STAT, 16'h0); #1;
    idle(3);
    cyc(1'b1, 1'b0, BASE, 16'h005A);
    idle(FRAME + 3);

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] a;
      int r;
      r = $urandom_range(0, 9);
      a = (r < 5) ? BASE : (r < 8) ? STAT : (r == 8) ? UNMAP : 16'($urandom);
      cyc(($urandom_range(0, 99) < 12), ($urandom_range(0, 3) == 0), a, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
